// File: rtl/iserdes_pkg.sv
// rtl/iserdes_pkg.sv - shared ISERDES alignment types and constants
// Holds the alignment FSM state encoding (also decoded by the CSR map)
// and the default frame-clock training pattern.
package iserdes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } align_state_e;

  localparam logic [7:0] FRAME_PATTERN_DEFAULT = 8'h0F;

endpackage

// File: rtl/frame_align_cnt.sv
// rtl/frame_align_cnt.sv - saturating up-counter with synchronous clear
// Ports:
//   sample_clk  clock
//   rst_n       asynchronous active-low reset
//   clr         clear to zero (wins over inc)
//   inc         increment, holding at MAX
//   count       current value, $clog2(MAX+1) bits wide
module frame_align_cnt #(
  parameter int MAX = 15,
  localparam int W  = $clog2(MAX + 1)
) (
  input  logic         sample_clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/frame_align_ctrl.sv
// rtl/frame_align_ctrl.sv - ISERDES frame-clock word alignment controller
// Issues bitslip pulses until the deserialized frame-clock word equals
// PATTERN, declares lock after LOCK_COUNT consecutive matches and drops
// lock after LOSS_COUNT consecutive misses.
// Ports:
//   sample_clk    clock
//   reset_n       asynchronous active-low reset (deassertion synchronised)
//   clk_data_out  deserialized frame-clock word
//   enable        1 runs alignment, 0 returns to IDLE
//   manual_slip   one-cycle request for a bitslip, IDLE with enable=0 only
//   bitslip       single-cycle pulse to the ISERDES
//   locked        1 in LOCKED
//   align_err     1 in FAIL
//   slip_pos      bitslip pulses issued since reset, modulo 8
//   state         current FSM state encoding
module frame_align_ctrl
  import iserdes_pkg::*;
#(
  parameter logic [7:0] PATTERN       = FRAME_PATTERN_DEFAULT,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         LOCK_COUNT    = 16,
  parameter int         LOSS_COUNT    = 4,
  parameter int         MAX_SLIPS     = 8
) (
  input  logic       sample_clk,
  input  logic       reset_n,
  input  logic [7:0] clk_data_out,
  input  logic       enable,
  input  logic       manual_slip,
  output logic       bitslip,
  output logic       locked,
  output logic       align_err,
  output logic [2:0] slip_pos,
  output logic [2:0] state
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int AW = $clog2(MAX_SLIPS + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  // Reset asserts immediately, releases two edges after reset_n rises.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  align_state_e  st;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] guard_cnt;   // cycles left before another pulse is allowed
  logic [MW-1:0] match_cnt;
  logic [LW-1:0] miss_cnt;
  logic [AW-1:0] att_cnt;
  logic          is_match;

  assign is_match = (clk_data_out == PATTERN);
  assign state    = st;

  // Match and miss counters only run while their own condition holds;
  // any other cycle returns them to zero, which gives the
  // "consecutive" semantics without extra bookkeeping.
  frame_align_cnt #(.MAX(LOCK_COUNT)) u_match_cnt (
    .sample_clk (sample_clk),
    .rst_n      (rst_n_int),
    .clr        (!(enable && st == ST_CHECK && is_match)),
    .inc        (1'b1),
    .count      (match_cnt)
  );

  frame_align_cnt #(.MAX(LOSS_COUNT)) u_miss_cnt (
    .sample_clk (sample_clk),
    .rst_n      (rst_n_int),
    .clr        (!(enable && st == ST_LOCKED && !is_match)),
    .inc        (1'b1),
    .count      (miss_cnt)
  );

  // Attempts are zeroed in LOCKED so a loss of lock starts a fresh run.
  frame_align_cnt #(.MAX(MAX_SLIPS)) u_att_cnt (
    .sample_clk (sample_clk),
    .rst_n      (rst_n_int),
    .clr        (!enable || st == ST_IDLE || st == ST_LOCKED),
    .inc        (st == ST_SLIP),
    .count      (att_cnt)
  );

  always_ff @(posedge sample_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      st         <= ST_IDLE;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      align_err  <= 1'b0;
      slip_pos   <= 3'd0;
      settle_cnt <= '0;
      guard_cnt  <= '0;
    end else begin
      bitslip <= 1'b0;
      if (guard_cnt != '0) guard_cnt <= guard_cnt - SW'(1);

      if (!enable) begin
        st        <= ST_IDLE;
        locked    <= 1'b0;
        align_err <= 1'b0;
        if (st == ST_IDLE && manual_slip && guard_cnt == '0) begin
          bitslip   <= 1'b1;
          slip_pos  <= slip_pos + 3'd1;
          guard_cnt <= SW'(SETTLE_CYCLES);
        end
      end else begin
        case (st)
          ST_IDLE: st <= ST_CHECK;
          ST_CHECK: begin
            if (is_match) begin
              if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                st     <= ST_LOCKED;
                locked <= 1'b1;
              end
            end else if (att_cnt == AW'(MAX_SLIPS)) begin
              st        <= ST_FAIL;
              align_err <= 1'b1;
            end else if (guard_cnt == '0) begin
              // Holding in CHECK while the guard runs keeps a recent
              // manual pulse and this automatic one far enough apart.
              st        <= ST_SLIP;
              bitslip   <= 1'b1;
              slip_pos  <= slip_pos + 3'd1;
              guard_cnt <= SW'(SETTLE_CYCLES);
            end
          end
          ST_SLIP: begin
            st         <= ST_SETTLE;
            settle_cnt <= '0;
          end
          ST_SETTLE: begin
            if (settle_cnt == SW'(SETTLE_CYCLES - 1)) st <= ST_CHECK;
            else settle_cnt <= settle_cnt + SW'(1);
          end
          ST_LOCKED: begin
            if (!is_match && miss_cnt == LW'(LOSS_COUNT - 1)) begin
              st     <= ST_CHECK;
              locked <= 1'b0;
            end
          end
          ST_FAIL: align_err <= 1'b1;
          default: begin
            st        <= ST_IDLE;
            locked    <= 1'b0;
            align_err <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_align_ctrl.sv
// tb/tb_frame_align_ctrl.sv - directed self-checking bench for frame_align_ctrl
module tb_frame_align_ctrl;
  import iserdes_pkg::*;

  logic       sample_clk = 1'b0;
  logic       reset_n;
  logic [7:0] clk_data_out;
  logic       enable;
  logic       manual_slip;
  logic       bitslip;
  logic       locked;
  logic       align_err;
  logic [2:0] slip_pos;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ISERDES model: each observed bitslip pulse rotates the word right by one.
  logic [7:0] base;
  int         mark;
  int         tb_slips = 0;
  logic       inject_bad;

  typedef struct {
    logic [2:0] pos;
    int         gap;   // required edges since previous pulse, 0 = unchecked
  } pulse_t;
  pulse_t exp_q[$];
  int     last_pulse = 0;

  function automatic logic [7:0] rotr8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < (n % 8); k++) r = {r[0], r[7:1]};
    return r;
  endfunction

  assign clk_data_out = inject_bad ? 8'hAA : rotr8(base, tb_slips - mark);

  frame_align_ctrl dut (
    .sample_clk   (sample_clk),
    .reset_n      (reset_n),
    .clk_data_out (clk_data_out),
    .enable       (enable),
    .manual_slip  (manual_slip),
    .bitslip      (bitslip),
    .locked       (locked),
    .align_err    (align_err),
    .slip_pos     (slip_pos),
    .state        (state)
  );

  always #5 sample_clk = ~sample_clk;
  always @(posedge sample_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every pulse must match the next queued expectation.
  always @(negedge sample_clk) begin
    if (bitslip === 1'b1) begin
      pulse_t e;
      checks++;
      assert (exp_q.size() != 0)
      else begin
        failures++;
        $error("FAIL unexpected_bitslip observed=pulse expected=none cyc=%0d", cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pulse_slip_pos", slip_pos, e.pos);
        if (e.gap != 0) chk("pulse_gap", cyc - last_pulse, e.gap);
      end
      last_pulse = cyc;
      tb_slips   = tb_slips + 1;
    end
  end

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bitslip"}, bitslip, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_align_err"}, align_err, 0);
    chk({tag, "_slip_pos"}, slip_pos, 0);
    chk({tag, "_state"}, state, ST_IDLE);
  endtask

  task automatic do_reset(input logic en, input logic [7:0] b);
    reset_n     = 1'b0;
    enable      = en;
    manual_slip = 1'b0;
    inject_bad  = 1'b0;
    base        = b;
    mark        = tb_slips;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_locked(input string tag, input int limit);
    int n = 0;
    while (locked !== 1'b1 && n < limit) begin tick(); n++; end
    chk(tag, locked, 1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; enable = 1'b0; manual_slip = 1'b0; inject_bad = 1'b0;
    base = 8'h0F; mark = 0;
    repeat (2) tick();
    chk_all_zero("reset");

    // Aligned input: no pulses, lock 16 cycles after the first CHECK sample.
    enable  = 1'b1;
    reset_n = 1'b1;
    tick();
    chk("sync_hold_first_edge", state, ST_IDLE);
    n = 0;
    while (state !== ST_CHECK && n < 10) begin tick(); n++; end
    chk("enter_check", state, ST_CHECK);
    repeat (15) tick();
    chk("aligned_not_yet_locked", locked, 0);
    tick();
    chk("aligned_locked", locked, 1);
    chk("aligned_state", state, ST_LOCKED);
    chk("aligned_slip_pos", slip_pos, 0);

    // Loss of lock: three misses are tolerated, the fourth drops lock.
    inject_bad = 1'b1;
    repeat (3) tick();
    chk("three_miss_locked", locked, 1);
    inject_bad = 1'b0;
    tick();
    chk("miss_recovered_state", state, ST_LOCKED);
    inject_bad = 1'b1;
    repeat (3) tick();
    chk("three_miss_again_locked", locked, 1);
    tick();
    chk("four_miss_unlocked", locked, 0);
    chk("four_miss_state", state, ST_CHECK);
    inject_bad = 1'b0;
    repeat (16) tick();
    chk("relock", locked, 1);
    chk("relock_slip_pos", slip_pos, 0);

    // Word rotated by three: three pulses with five idle cycles between.
    exp_q.push_back('{pos: 3'd1, gap: 0});
    exp_q.push_back('{pos: 3'd2, gap: 6});
    exp_q.push_back('{pos: 3'd3, gap: 6});
    do_reset(1'b1, 8'h78);
    wait_locked("rot3_locked", 300);
    chk("rot3_slip_pos", slip_pos, 3);
    chk("rot3_queue_empty", exp_q.size(), 0);

    // Never matching: eight pulses then FAIL until enable drops.
    for (int i = 0; i < 8; i++) exp_q.push_back('{pos: 3'((i + 1) % 8), gap: (i == 0) ? 0 : 6});
    do_reset(1'b1, 8'hAA);
    n = 0;
    while (align_err !== 1'b1 && n < 300) begin tick(); n++; end
    chk("fail_align_err", align_err, 1);
    chk("fail_locked", locked, 0);
    chk("fail_state", state, ST_FAIL);
    chk("fail_slip_pos_wrap", slip_pos, 0);
    chk("fail_queue_empty", exp_q.size(), 0);
    repeat (5) tick();
    chk("fail_held", align_err, 1);
    enable = 1'b0;
    tick();
    chk("fail_exit_state", state, ST_IDLE);
    chk("fail_exit_err", align_err, 0);

    // Manual slips in IDLE with enable=0 at cycles 10 and 20.
    exp_q.push_back('{pos: 3'd1, gap: 0});
    exp_q.push_back('{pos: 3'd2, gap: 10});
    do_reset(1'b0, 8'h0F);
    repeat (3) tick();
    for (int c = 0; c < 30; c++) begin
      manual_slip = (c == 10 || c == 20);
      tick();
    end
    manual_slip = 1'b0;
    tick();
    chk("manual_slip_pos", slip_pos, 2);
    chk("manual_queue_empty", exp_q.size(), 0);

    // A held request yields one pulse thanks to the spacing guard.
    exp_q.push_back('{pos: 3'd3, gap: 0});
    manual_slip = 1'b1;
    repeat (3) tick();
    manual_slip = 1'b0;
    repeat (8) tick();
    chk("manual_held_slip_pos", slip_pos, 3);
    chk("manual_held_queue_empty", exp_q.size(), 0);

    // Manual requests while enabled are ignored.
    mark   = tb_slips;
    enable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      manual_slip = (c % 4 == 1);
      tick();
    end
    manual_slip = 1'b0;
    chk("manual_enabled_slip_pos", slip_pos, 3);

    // Reset during the bitslip pulse truncates it at once.
    do_reset(1'b1, 8'hAA);
    n = 0;
    while (bitslip !== 1'b1 && n < 50) begin tick(); n++; end
    chk("pulse_seen_before_reset", bitslip, 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("reset_in_pulse");
    repeat (2) tick();

    // Reset during SETTLE.
    mark = tb_slips;
    exp_q.push_back('{pos: 3'd1, gap: 0});
    reset_n = 1'b1;
    n = 0;
    while (state !== ST_SETTLE && n < 50) begin tick(); n++; end
    chk("settle_reached", state, ST_SETTLE);
    reset_n = 1'b0;
    #1;
    chk_all_zero("reset_in_settle");
    chk("settle_queue_empty", exp_q.size(), 0);

    // Clean restart after release with aligned input.
    base = 8'h0F;
    mark = tb_slips;
    repeat (2) tick();
    reset_n = 1'b1;
    wait_locked("restart_locked", 100);
    chk("restart_slip_pos", slip_pos, 0);
    chk("restart_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_align_ctrl.md
FRAME_ALIGN_CTRL -- requirements
Module: frame_align_ctrl

Interface
REQ-001 Parameter PATTERN, default 8'h0F, expected frame-clock word on clk_data_out when aligned.
REQ-002 Parameter SETTLE_CYCLES, default 4, wait cycles after each bitslip pulse before comparing.
REQ-003 Parameter LOCK_COUNT, default 16, consecutive matches required to declare lock.
REQ-004 Parameter LOSS_COUNT, default 4, consecutive mismatches in LOCKED that declare loss of lock.
REQ-005 Parameter MAX_SLIPS, default 8, bitslip attempts allowed per alignment run before failure.
REQ-006 sample_clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 clk_data_out  input  8  deserialized frame-clock word, one word per sample_clk.
REQ-009 enable  input  1  level; 1 runs automatic alignment, 0 forces IDLE.
REQ-010 manual_slip  input  1  single-cycle request for one bitslip; honoured only in IDLE.
REQ-011 bitslip  output  1  registered single-cycle pulse to the ISERDES bitslip input.
REQ-012 locked  output  1  registered; 1 only in LOCKED.
REQ-013 align_err  output  1  registered; 1 only in FAIL.
REQ-014 slip_pos  output  3  bitslip pulses issued since reset, modulo 8.
REQ-015 state  output  3  current state encoding, for debug/CSR readback.

Function
REQ-016 States: IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL.
REQ-017 IDLE: match, miss and attempt counters held at 0; enable=1 -> CHECK next cycle.
REQ-018 IDLE with manual_slip=1 and enable=0: bitslip=1 for exactly the next cycle; slip_pos increments.
REQ-019 CHECK: clk_data_out==PATTERN increments match counter; on the LOCK_COUNT-th consecutive match -> LOCKED.
REQ-020 CHECK mismatch: match counter cleared; attempts==MAX_SLIPS -> FAIL, else -> SLIP.
REQ-021 SLIP: lasts one cycle; bitslip=1, attempts+1, slip_pos+1 (wraps 7->0); -> SETTLE.
REQ-022 SETTLE: lasts exactly SETTLE_CYCLES cycles; clk_data_out ignored; then -> CHECK with match counter 0.
REQ-023 LOCKED: match clears miss counter; mismatch increments it; the LOSS_COUNT-th consecutive miss -> CHECK with attempts and match counter cleared, locked=0 from that cycle.
REQ-024 FAIL: align_err held 1; exits only via enable=0 -> IDLE.
REQ-025 enable=0 in any state -> IDLE next cycle; a SLIP in progress completes its single pulse, and no further pulse is issued.
REQ-026 manual_slip outside IDLE, or with enable=1, is ignored; never two bitslip pulses closer than SETTLE_CYCLES+1 cycles.
REQ-027 Counters saturate, never wrap: match at LOCK_COUNT, miss at LOSS_COUNT, attempts at MAX_SLIPS; widths are $clog2(max+1).
REQ-028 Latency: the first matching word sampled in CHECK to locked=1 is LOCK_COUNT cycles.

Reset
REQ-029 reset_n=0 asynchronously forces IDLE, bitslip=0, locked=0, align_err=0, slip_pos=0, state=IDLE, all counters 0.
REQ-030 Reset deassertion is synchronised internally (two-flop); first transition is no earlier than the 2nd rising edge after release.
REQ-031 Reset mid-SLIP truncates the bitslip pulse immediately.

Structure
REQ-032 The state enumeration and the default PATTERN constant live in the shared iserdes package, also used by the CSR map.
REQ-033 One sub-module, frame_align_cnt (parameterised saturating counter with clear and increment), instanced three times for match, miss and attempts.

Verification
REQ-034 Reset with aligned input (8'h0F constant), enable=1 -> zero bitslip pulses, locked=1 on the 16th CHECK cycle, slip_pos=0.
REQ-035 Input rotated by 3 bits (8'h78 → model rotates per pulse), enable=1 -> exactly 3 pulses, each separated by 5 cycles, then locked=1, slip_pos=3.
REQ-036 Input never matches (8'hAA) -> 8 pulses, then align_err=1, locked=0; enable 1->0 -> IDLE, align_err=0.
REQ-037 In LOCKED, inject 3 mismatches then 1 match -> stays locked; inject 4 consecutive mismatches -> locked=0 and re-enter CHECK on the next cycle.
REQ-038 enable=0 with manual_slip pulses on cycles 10 and 20 -> two single-cycle bitslip pulses, slip_pos=2; manual_slip while enable=1 -> no pulse.
REQ-039 Assert reset_n=0 during SETTLE and during the bitslip pulse -> all outputs 0 within the same cycle; alignment restarts cleanly after release.
